// File: rtl/memory_interface.sv
// MAR/MDR front end to a wait-stated word array; optional MMIO window under `MMIO_EN.
// Latency: mem_ready in cycle WAIT_STATES+2 counted from the mem_en sample edge (cycle 1 follows that edge).
// Backpressure: none; mem_en while busy is dropped, and MAR (and MDR on writes) loads are frozen while busy.
module memory_interface #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] bus_in,
    input  logic              ld_mar,
    input  logic              ld_mdr,
    input  logic              ld_mar_spc,
    input  logic [ADDR_W-1:0] mar_spc_in,
    input  logic [1:0]        sel_mdr,
    input  logic [DATA_W-1:0] mdr_spc_in,
    input  logic              mem_en,
    input  logic              mem_we,
`ifdef MMIO_EN
    output logic [ADDR_W-1:0] io_addr,
    output logic [DATA_W-1:0] io_wdata,
    output logic              io_we,
    output logic              io_re,
    input  logic [DATA_W-1:0] io_rdata,
`endif
    output logic [ADDR_W-1:0] mar_out,
    output logic [DATA_W-1:0] mdr_out,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q;
    logic              is_io;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] mem [2**MEM_AW];

    wire [MEM_AW-1:0] idx    = mar_out[MEM_AW-1:0];
    wire              finish = (state == WAIT) && (cnt == 4'd0);

`ifdef MMIO_EN
    assign is_io    = &mar_out[ADDR_W-1:ADDR_W-7];
    assign rd_word  = is_io ? io_rdata : mem[idx];
    assign io_addr  = mar_out;
    assign io_wdata = mdr_out;

    // Strobes are registered so they coincide exactly with the DONE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            io_we <= 1'b0;
            io_re <= 1'b0;
        end else begin
            io_we <= finish && we_q && is_io;
            io_re <= finish && !we_q && is_io;
        end
    end
`else
    assign is_io   = 1'b0;
    assign rd_word = mem[idx];
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
            mem_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_en) begin
                        state <= WAIT;
                        cnt   <= WS;
                        we_q  <= mem_we;
                        busy  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state     <= DONE;
                        mem_ready <= 1'b1;
                        if (!we_q)
                            mem_rdata <= rd_word;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // MDR stays loadable during reads so the DONE cycle can pick up fresh read data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mar_out <= '0;
            mdr_out <= '0;
        end else begin
            if (!busy) begin
                if (ld_mar_spc)
                    mar_out <= mar_spc_in;
                else if (ld_mar)
                    mar_out <= bus_in[ADDR_W-1:0];
            end
            if (ld_mdr && !(busy && we_q)) begin
                case (sel_mdr)
                    2'b00:   mdr_out <= bus_in;
                    2'b01:   mdr_out <= mem_rdata;
                    2'b11:   mdr_out <= mdr_spc_in;
                    default: mdr_out <= mdr_out;
                endcase
            end
        end
    end

    // Array is not reset; reset forces IDLE so an aborted write never commits.
    always_ff @(posedge clk) begin
        if (state == DONE && we_q && !is_io)
            mem[idx] <= mdr_out;
    end

endmodule

// File: tb/tb_memory_interface.sv
// Directed bench: WAIT_STATES=2 main instance plus a WAIT_STATES=0 instance on shared stimulus.
module tb_memory_interface;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] bus_in = '0, mar_spc_in = '0, mdr_spc_in = '0;
    logic        ld_mar = 1'b0, ld_mdr = 1'b0, ld_mar_spc = 1'b0;
    logic [1:0]  sel_mdr = 2'b00;
    logic        mem_en = 1'b0, mem_we = 1'b0;

    logic [15:0] mar_out, mdr_out, mem_rdata;
    logic        mem_ready, busy;
    logic [15:0] mar0, mdr0, rdata0;
    logic        ready0, busy0;

`ifdef MMIO_EN
    logic [15:0] io_addr, io_wdata, io_addr0, io_wdata0;
    logic        io_we, io_re, io_we0, io_re0;
    logic [15:0] io_rdata = 16'h0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_interface #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .WAIT_STATES(2)) dut (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .ld_mar_spc(ld_mar_spc), .mar_spc_in(mar_spc_in), .sel_mdr(sel_mdr),
        .mdr_spc_in(mdr_spc_in), .mem_en(mem_en), .mem_we(mem_we),
`ifdef MMIO_EN
        .io_addr(io_addr), .io_wdata(io_wdata), .io_we(io_we), .io_re(io_re),
        .io_rdata(io_rdata),
`endif
        .mar_out(mar_out), .mdr_out(mdr_out), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy)
    );

    memory_interface #(.DATA_W(16), .ADDR_W(16), .MEM_AW(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus_in(bus_in), .ld_mar(ld_mar), .ld_mdr(ld_mdr),
        .ld_mar_spc(ld_mar_spc), .mar_spc_in(mar_spc_in), .sel_mdr(sel_mdr),
        .mdr_spc_in(mdr_spc_in), .mem_en(mem_en), .mem_we(mem_we),
`ifdef MMIO_EN
        .io_addr(io_addr0), .io_wdata(io_wdata0), .io_we(io_we0), .io_re(io_re0),
        .io_rdata(io_rdata),
`endif
        .mar_out(mar0), .mdr_out(mdr0), .mem_rdata(rdata0),
        .mem_ready(ready0), .busy(busy0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mdr(input logic [15:0] val);
        ld_mdr = 1'b1; sel_mdr = 2'b11; mdr_spc_in = val;
        step();
        ld_mdr = 1'b0;
    endtask

    // Starts an access with MAR loaded on the same edge; returns in the DONE cycle.
    // Cycle 1 is the cycle right after the mem_en sample edge.
    task automatic do_access(input logic we, input logic [15:0] addr, input logic meddle,
                             output int rdy_cyc, output int rdy0_cyc);
        int cyc;
        ld_mar = 1'b1; bus_in = addr; mem_en = 1'b1; mem_we = we;
        step();
        ld_mar = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
        if (meddle) begin
            ld_mar = 1'b1; ld_mdr = 1'b1; sel_mdr = 2'b00; bus_in = 16'h0099;
        end
        cyc = 1; rdy_cyc = -1; rdy0_cyc = -1;
        while (cyc < 40) begin
            if (ready0 && rdy0_cyc < 0) rdy0_cyc = cyc;
            if (mem_ready) begin
                rdy_cyc = cyc;
                break;
            end
            step();
            cyc++;
        end
        ld_mar = 1'b0; ld_mdr = 1'b0;
    endtask

    int r, r0;

    initial begin
        #12;
        check("rst_mar", mar_out, 16'h0);
        check("rst_mdr", mdr_out, 16'h0);
        check("rst_rdata", mem_rdata, 16'h0);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;
        step();

        // Special MAR source wins over the bus
        ld_mar_spc = 1'b1; mar_spc_in = 16'h0020; ld_mar = 1'b1; bus_in = 16'h0030;
        step();
        ld_mar_spc = 1'b0;
        check("mar_spc_prio", mar_out, 16'h0020);
        step();
        ld_mar = 1'b0;
        check("mar_bus", mar_out, 16'h0030);

        // MDR sources
        load_mdr(16'h1234);
        check("mdr_spc", mdr_out, 16'h1234);
        ld_mdr = 1'b1; sel_mdr = 2'b10; bus_in = 16'hAAAA;
        step();
        check("mdr_reserved_hold", mdr_out, 16'h1234);
        sel_mdr = 2'b00; bus_in = 16'hBEEF;
        step();
        ld_mdr = 1'b0;
        check("mdr_bus", mdr_out, 16'hBEEF);

        // Write 0xBEEF to 0x0005 with MAR loaded on the start edge
        do_access(1'b1, 16'h0005, 1'b0, r, r0);
        check("wr_mar_same_edge", mar_out, 16'h0005);
        check("wr_ready_cycle", r, 4);
        check("wr_ready_cycle_ws0", r0, 2);
        check("wr_busy_done", busy, 1'b1);
        step();
        check("wr_ready_drop", mem_ready, 1'b0);
        check("wr_busy_drop", busy, 1'b0);

        // Loads during a write are frozen
        load_mdr(16'h1111);
        do_access(1'b1, 16'h0006, 1'b1, r, r0);
        step();
        check("wr_inhibit_mar", mar_out, 16'h0006);
        check("wr_inhibit_mdr", mdr_out, 16'h1111);

        // Readback of 0x0006 captured into MDR in the DONE cycle
        load_mdr(16'h2222);
        do_access(1'b0, 16'h0006, 1'b0, r, r0);
        check("rd6_rdata", mem_rdata, 16'h1111);
        ld_mdr = 1'b1; sel_mdr = 2'b01;
        step();
        ld_mdr = 1'b0;
        check("rd6_mdr_capture", mdr_out, 16'h1111);

        // Read back 0x0005
        do_access(1'b0, 16'h0005, 1'b0, r, r0);
        check("rd5_ready_cycle", r, 4);
        check("rd5_rdata", mem_rdata, 16'hBEEF);
        step();

        // Aliased read at 0x0405
        do_access(1'b0, 16'h0405, 1'b0, r, r0);
        check("alias_ready_ws0", r0, 2);
        check("alias_rdata_ws0", rdata0, 16'hBEEF);
        check("alias_rdata", mem_rdata, 16'hBEEF);
        step();

        // Reset mid-WAIT of a write to 0x0005
        load_mdr(16'h5555);
        ld_mar = 1'b1; bus_in = 16'h0005; mem_en = 1'b1; mem_we = 1'b1;
        step();
        ld_mar = 1'b0; mem_en = 1'b0; mem_we = 1'b0;
        step();
        check("pre_rst_busy", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_mar", mar_out, 16'h0);
        check("mid_rst_mdr", mdr_out, 16'h0);
        check("mid_rst_rdata", mem_rdata, 16'h0);
        check("mid_rst_ready", mem_ready, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        step();
        step();
        reset = 1'b1;
        step();
        do_access(1'b0, 16'h0005, 1'b0, r, r0);
        check("post_rst_accept", r, 4);
        check("post_rst_word", mem_rdata, 16'hBEEF);
        step();

`ifdef MMIO_EN
        // MMIO write must not touch the aliased array word 0x202
        load_mdr(16'h7777);
        do_access(1'b1, 16'h0202, 1'b0, r, r0);
        step();
        load_mdr(16'h0041);
        do_access(1'b1, 16'hFE02, 1'b0, r, r0);
        check("io_we_done", io_we, 1'b1);
        check("io_addr", io_addr, 16'hFE02);
        check("io_wdata", io_wdata, 16'h0041);
        step();
        check("io_we_pulse", io_we, 1'b0);
        do_access(1'b0, 16'h0202, 1'b0, r, r0);
        check("io_array_unchanged", mem_rdata, 16'h7777);
        step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
